dac_sequencer: RTL

DAC_SEQUENCER -- requirements
Module: dac_sequencer

---
 rtl/dac_sequencer_pkg.sv | 19 +
 rtl/dac_segment_encoder.sv | 29 ++
 rtl/dac_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/dac_sequencer_pkg.sv
// Shared types and sizing constants for the DAC power/calibration sequencer.
// Holds the FSM state encoding and the segmented DAC geometry.
package dac_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_PWRUP = 2'd1,
    ST_CAL   = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  localparam int N_THERM    = 17;
  localparam int N_BIN      = 7;
  localparam int FULL_SCALE = 1151;
  localparam int ATB_LINES  = 10;
  localparam int CODE_W     = 11;
  localparam int CNT_W      = 16;

endpackage

// File: rtl/dac_segment_encoder.sv
// Combinational clamp and split of an 11-bit code into 17 thermometer units
// (64 LSB each) plus a 7-bit binary drive with a redundant bit0 slot.
module dac_segment_encoder
  import dac_sequencer_pkg::*;
(
  input  logic [CODE_W-1:0]  code,
  output logic [N_THERM-1:0] therm,
  output logic [N_BIN-1:0]   bin
);

  function automatic logic [CODE_W-1:0] sat_code(input logic [CODE_W-1:0] c);
    return (c > CODE_W'(FULL_SCALE)) ? CODE_W'(FULL_SCALE) : c;
  endfunction

  logic [CODE_W-1:0] code_sat;
  logic [4:0]        t_units;

  always_comb begin
    code_sat = sat_code(code);
    t_units  = code_sat[10:6];
    therm    = '0;
    for (int i = 0; i < N_THERM; i++) begin
      therm[i] = (5'(i) < t_units);
    end
    // bit0_red (slot 1) is never driven; bits 1..5 sit in slots 2..6
    bin = {code_sat[5:1], 1'b0, code_sat[0]};
  end

endmodule

// File: rtl/dac_sequencer.sv
// DAC sequencer: power-up settle, calibration and run FSM, registered code
// drive with true/complement outputs, and break-before-make ATB selection.
module dac_sequencer
  import dac_sequencer_pkg::*;
#(
  parameter int SETTLE_CYC = 256,
  parameter int CAL_CYC    = 64
)(
  input  logic                 clkin,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 cal_req,
  input  logic                 code_valid,
  input  logic [CODE_W-1:0]    code_in,
  output logic                 code_ready,
  input  logic                 atb_en,
  input  logic [3:0]           atb_sel,
  output logic                 pdb,
  output logic                 dataical,
  output logic [N_THERM-1:0]   dataintherm,
  output logic [N_THERM-1:0]   datainthermb,
  output logic [N_BIN-1:0]     datainbin,
  output logic [N_BIN-1:0]     datainbinb,
  output logic [ATB_LINES-1:0] atb_ena,
  output logic [1:0]           state
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CAL_LAST    = CNT_W'(CAL_CYC - 1);

  state_t             state_q;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept;
  logic [N_THERM-1:0] enc_therm;
  logic [N_BIN-1:0]   enc_bin;
  logic [N_THERM-1:0] therm_p0;
  logic [N_BIN-1:0]   bin_p0;
  logic [ATB_LINES-1:0] atb_tgt;
  logic [ATB_LINES-1:0] atb_prev_q;
  logic [ATB_LINES-1:0] atb_ena_q;

  always_ff @(posedge clkin) begin
    if (rst) state_q <= ST_OFF;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    if (!enable) begin
      state_nxt = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:   state_nxt = ST_PWRUP;
        ST_PWRUP: if (cnt_q == SETTLE_LAST) state_nxt = ST_CAL;
        ST_CAL:   if (cnt_q == CAL_LAST)    state_nxt = ST_RUN;
        ST_RUN:   if (cal_req)              state_nxt = ST_CAL;
        default:  state_nxt = ST_OFF;
      endcase
    end
  end

  always_comb begin
    pdb        = (state_q != ST_OFF);
    dataical   = (state_q == ST_CAL);
    code_ready = (state_q == ST_RUN);
  end

  assign state = state_q;

  // Shared dwell counter: zero on every state entry, counts in PWRUP/CAL
  always_ff @(posedge clkin) begin
    if (rst || (state_nxt != state_q))
      cnt_q <= '0;
    else if ((state_q == ST_PWRUP) || (state_q == ST_CAL))
      cnt_q <= cnt_q + 1'b1;
  end

  assign accept = code_valid && code_ready && !cal_req;

  dac_segment_encoder u_enc (
    .code  (code_in),
    .therm (enc_therm),
    .bin   (enc_bin)
  );

  // Stage p0: drive register, forced to code 0 whenever the next state is not RUN
  always_ff @(posedge clkin) begin
    if (rst || (state_nxt != ST_RUN)) begin
      therm_p0 <= '0;
      bin_p0   <= '0;
    end else if (accept) begin
      therm_p0 <= enc_therm;
      bin_p0   <= enc_bin;
    end
  end

  assign dataintherm  = therm_p0;
  assign datainthermb = ~therm_p0;
  assign datainbin    = bin_p0;
  assign datainbinb   = ~bin_p0;

  always_comb begin
    atb_tgt = '0;
    if (atb_en && (atb_sel <= 4'(ATB_LINES - 1)))
      atb_tgt = ATB_LINES'(1) << atb_sel;
  end

  // A new target first opens all switches for one cycle, then closes the new line
  always_ff @(posedge clkin) begin
    if (rst) begin
      atb_prev_q <= '0;
      atb_ena_q  <= '0;
    end else if (atb_tgt != atb_prev_q) begin
      atb_prev_q <= atb_tgt;
      atb_ena_q  <= '0;
    end else begin
      atb_ena_q  <= atb_tgt;
    end
  end

  assign atb_ena = atb_ena_q;

endmodule
